// File: rtl/irq_ctrl.sv
// irq_ctrl: Avalon-MM interrupt aggregator with per-source pending, mask, mode and a priority vector.
// Optional: define IRQ_CTRL_SYNC_EN to add a two-flop synchronizer on every src_irq line. Rev 1.0
`default_nettype none

module irq_ctrl #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] EDGE_DEFAULT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] src_irq,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_FORCE   = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mask_next;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] mode_next;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] force_set;
  logic [NUM_IRQ-1:0] active;
  logic               wr;
  logic               vec_valid;
  logic [3:0]         vec_idx;
  logic [15:0]        rd_mux;
  logic               unused_wdata;

  assign unused_wdata = ^writedata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_irq;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src_irq;
`endif

  assign rise = s & ~prev;
  assign wr   = chipselect && !write_n;

  assign w1c       = (wr && address == ADDR_PENDING) ? writedata[NUM_IRQ-1:0] : '0;
  assign force_set = (wr && address == ADDR_FORCE)   ? writedata[NUM_IRQ-1:0] : '0;
  assign mask_next = (wr && address == ADDR_MASK)    ? writedata[NUM_IRQ-1:0] : mask;
  assign mode_next = (wr && address == ADDR_MODE)    ? writedata[NUM_IRQ-1:0] : mode;

  // Current MODE selects the behaviour, so a mode write only takes effect on the following cycle.
  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
      always_comb begin
        pending_next[i] = pending[i];
        if (!mode[i]) begin
          pending_next[i] = s[i];
        end else if (rise[i] || force_set[i]) begin
          pending_next[i] = 1'b1;
        end else if (w1c[i]) begin
          pending_next[i] = 1'b0;
        end
      end
    end
  endgenerate

  assign active = pending & mask;

  always_comb begin
    vec_valid = 1'b0;
    vec_idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_valid = 1'b1;
        vec_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      ADDR_PENDING: rd_mux[NUM_IRQ-1:0] = pending;
      ADDR_MASK:    rd_mux[NUM_IRQ-1:0] = mask;
      ADDR_MODE:    rd_mux[NUM_IRQ-1:0] = mode;
      ADDR_VECTOR:  rd_mux = {vec_valid, 11'b0, vec_idx};
      ADDR_RAW:     rd_mux[NUM_IRQ-1:0] = s;
      default:      rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      pending  <= '0;
      mask     <= '0;
      mode     <= EDGE_DEFAULT[NUM_IRQ-1:0];
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      prev     <= s;
      pending  <= pending_next;
      mask     <= mask_next;
      mode     <= mode_next;
      readdata <= rd_mux;
      // Built from the next-state values so irq tracks pending/mask on the same edge.
      irq      <= |(pending_next & mask_next);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven register checks plus hand-written multi-cycle sequences for irq_ctrl.
`default_nettype none

module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [7:0]  src_irq;
  logic [15:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int          op;    // 0 write, 1 read, 2 irq check
    logic [2:0]  addr;
    logic [15:0] data;  // write data, or expected value
    string       name;
  } vec_t;

  irq_ctrl #(.NUM_IRQ(8), .EDGE_DEFAULT(16'hFFFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .src_irq    (src_irq),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // All tasks start and end on a negedge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    sb_t e;
    address = a;
    sb.push_back('{exp, name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, readdata, e.exp);
    @(negedge clk);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    chk(name, {15'b0, irq}, {15'b0, exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  vec_t vt[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and FORCE/W1C/VECTOR table
    vt.push_back('{1, 3'd0, 16'h0000, "rst_pending"});
    vt.push_back('{1, 3'd1, 16'h0000, "rst_mask"});
    vt.push_back('{1, 3'd2, 16'h00FF, "rst_mode"});
    vt.push_back('{1, 3'd3, 16'h0000, "rst_force"});
    vt.push_back('{1, 3'd4, 16'h0000, "rst_vector"});
    vt.push_back('{1, 3'd5, 16'h0000, "rst_raw"});
    vt.push_back('{1, 3'd6, 16'h0000, "rst_a6"});
    vt.push_back('{1, 3'd7, 16'h0000, "rst_a7"});
    vt.push_back('{2, 3'd0, 16'h0000, "rst_irq"});

    reset = 1'b1; address = 3'd2; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'h0; src_irq = 8'h00;
    tick(3);
    reset = 1'b0;
    chk("rst_readdata", readdata, 16'h0000);

    foreach (vt[i]) begin
      case (vt[i].op)
        0: wr(vt[i].addr, vt[i].data);
        1: rd(vt[i].addr, vt[i].data, vt[i].name);
        default: chk_irq(vt[i].data[0], vt[i].name);
      endcase
    end

    // Single-cycle pulse on src 2 with mask enabled
    wr(3'd1, 16'h0004);
    src_irq = 8'h04;
    tick(1);
    src_irq = 8'h00;
    chk_irq(LAT == 0, "t2_irq_latency");
    tick(2);
    chk_irq(1'b1, "t2_irq_set");
    rd(3'd0, 16'h0004, "t2_pending");
    rd(3'd4, 16'h8002, "t2_vector");
    wr(3'd0, 16'h0004);
    chk_irq(1'b0, "t2_irq_clr");

    vt.delete();
    vt.push_back('{0, 3'd1, 16'h00FF, ""});
    vt.push_back('{0, 3'd3, 16'h0030, ""});
    vt.push_back('{2, 3'd0, 16'h0001, "t3_irq_force"});
    vt.push_back('{1, 3'd0, 16'h0030, "t3_pending"});
    vt.push_back('{1, 3'd3, 16'h0000, "t3_force_rd"});
    vt.push_back('{1, 3'd4, 16'h8004, "t3_vec4"});
    vt.push_back('{0, 3'd0, 16'h0010, ""});
    vt.push_back('{1, 3'd4, 16'h8005, "t3_vec5"});
    vt.push_back('{0, 3'd0, 16'h0020, ""});
    vt.push_back('{1, 3'd0, 16'h0000, "t3_pending_clr"});
    vt.push_back('{2, 3'd0, 16'h0000, "t3_irq_clr"});
    foreach (vt[i]) begin
      case (vt[i].op)
        0: wr(vt[i].addr, vt[i].data);
        1: rd(vt[i].addr, vt[i].data, vt[i].name);
        default: chk_irq(vt[i].data[0], vt[i].name);
      endcase
    end

    // Level-mode source 0
    wr(3'd2, 16'h00FE);
    wr(3'd1, 16'h0001);
    src_irq = 8'h01;
    tick(LAT + 2);
    chk_irq(1'b1, "t4_irq_level");
    wr(3'd0, 16'h0001);
    rd(3'd0, 16'h0001, "t4_w1c_ignored");
    rd(3'd5, 16'h0001, "t4_raw");
    src_irq = 8'h00;
    tick(LAT + 2);
    rd(3'd0, 16'h0000, "t4_pending_drop");
    chk_irq(1'b0, "t4_irq_drop");
    wr(3'd2, 16'h00FF);

    // Rise on src 3 in the same cycle as its W1C: set wins
    wr(3'd1, 16'h0008);
    src_irq = 8'h08;
    tick(LAT);
    wr(3'd0, 16'h0008);
    rd(3'd0, 16'h0008, "t5_set_wins");
    chk_irq(1'b1, "t5_irq");
    wr(3'd0, 16'h0008);
    tick(2);
    rd(3'd0, 16'h0000, "t5_held_no_repend");
    chk_irq(1'b0, "t5_irq_clr");
    src_irq = 8'h00;
    tick(LAT + 2);

    // Masked pending, unmask, then reset mid-pending
    wr(3'd1, 16'h0000);
    src_irq = 8'h02;
    tick(1);
    src_irq = 8'h00;
    tick(LAT + 1);
    rd(3'd0, 16'h0002, "t6_masked_pending");
    chk_irq(1'b0, "t6_irq_masked");
    wr(3'd1, 16'h0002);
    chk_irq(1'b1, "t6_irq_unmask");
    wr(3'd2, 16'h000F);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_irq(1'b0, "t6_irq_reset");
    rd(3'd0, 16'h0000, "t6_pending_reset");
    rd(3'd1, 16'h0000, "t6_mask_reset");
    rd(3'd2, 16'h00FF, "t6_mode_reset");
    rd(3'd4, 16'h0000, "t6_vector_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
